// File: rtl/noc_inject_pkg.sv
// Shared definitions for the NoC injection scheduler slice.
// Holds the sizing constants, the scheduler state encoding, the mode
// encodings and a popcount helper used to total per-cycle valid pulses.
package noc_inject_pkg;

    localparam int NUM_NODES = 16;
    localparam int NODE_W    = 4;
    localparam int BUF_DEPTH = 30;
    localparam int CNT_W     = 5;
    localparam int TOT_W     = 10;
    localparam int TIMEOUT   = 64;
    localparam int GAP_W     = 8;
    localparam int WD_W      = 7;
    localparam int POP_W     = NODE_W + 1;

    localparam logic MODE_SEQ  = 1'b0;
    localparam logic MODE_CONC = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } sched_state_t;

    // Number of set bits in a node-wide vector.
    function automatic logic [POP_W-1:0] popcount(input logic [NUM_NODES-1:0] vec);
        logic [POP_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < NUM_NODES; i++) begin
            sum = sum + {{(POP_W-1){1'b0}}, vec[i]};
        end
        return sum;
    endfunction

endpackage

// File: rtl/inject_scheduler_if.sv
// Control/status bundle between the injection scheduler and its environment.
// master: the controller plus buffer side (drives start, mode, gap_cycles,
//         hold, node_valid; observes node_en and status).
// slave:  the scheduler itself.
interface inject_scheduler_if;
    import noc_inject_pkg::*;

    logic                 start;
    logic                 mode;
    logic [GAP_W-1:0]     gap_cycles;
    logic                 hold;
    logic [NUM_NODES-1:0] node_valid;
    logic [NUM_NODES-1:0] node_en;
    logic [NODE_W-1:0]    cur_node;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [TOT_W-1:0]     words_seen;

    modport master (
        output start, mode, gap_cycles, hold, node_valid,
        input  node_en, cur_node, busy, done, err, words_seen
    );

    modport slave (
        input  start, mode, gap_cycles, hold, node_valid,
        output node_en, cur_node, busy, done, err, words_seen
    );

endinterface

// File: rtl/inject_watchdog.sv
// Progress watchdog for the injection scheduler.
// Ports: clk, rst (async active-low); clear zeroes the count and has priority;
// enable advances the count (saturating at LIMIT); fire is high while the
// count sits at LIMIT.
module inject_watchdog #(
    parameter int LIMIT = 64,
    parameter int W     = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic fire
);

    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

    logic [W-1:0] cnt_r;
    logic [W-1:0] cnt_s;
    logic         fire_r;

    // Next count: clear wins, otherwise count up until the limit is reached.
    always_comb begin
        cnt_s = cnt_r;
        if (clear) begin
            cnt_s = '0;
        end else if (enable && (cnt_r != LIMIT_V)) begin
            cnt_s = cnt_r + W'(1);
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Count register and registered fire flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r  <= '0;
            fire_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_s;
            fire_r <= (cnt_s == LIMIT_V);
        end
    end

    assign fire = fire_r;

endmodule

// File: rtl/inject_scheduler.sv
// Sequences the per-node one-shot injection buffers feeding the NoC.
// Ports: clk, rst (async active-low), bus (inject_scheduler_if.slave):
//   start/mode/gap_cycles select and launch a schedule, hold pauses all
//   enables, node_valid are the buffer out_valid pulses, node_en the buffer
//   enables, cur_node/busy/done/err/words_seen report progress.
// All outputs are registered. node_en is computed from the next state and
// next counters, so an enable drops on the same edge that records a node's
// last word, and a GAP of N cycles yields exactly N all-zero enable cycles.
module inject_scheduler
    import noc_inject_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    inject_scheduler_if.slave bus
);

    localparam logic [CNT_W-1:0]  FULL      = CNT_W'(BUF_DEPTH);
    localparam logic [NODE_W-1:0] LAST_NODE = NODE_W'(NUM_NODES - 1);

    sched_state_t         state_r, state_s;
    logic                 mode_r, mode_s;
    logic [GAP_W-1:0]     gap_r, gap_s;
    logic [GAP_W-1:0]     gap_cnt_r, gap_cnt_s;
    logic [NODE_W-1:0]    cur_r, cur_s;
    logic [CNT_W-1:0]     cnt_r [NUM_NODES];
    logic [CNT_W-1:0]     cnt_s [NUM_NODES];
    logic [TOT_W-1:0]     words_r, words_s;
    logic                 err_r, err_s;
    logic [NUM_NODES-1:0] en_r, en_s;
    logic                 busy_r, done_r;
    logic [NUM_NODES-1:0] elig_s, good_s, stray_s;
    logic [TOT_W:0]       words_sum_s;
    logic                 all_full_s;
    logic                 wd_clear_s, wd_enable_s, wd_fire_s;

    inject_watchdog #(
        .LIMIT (TIMEOUT),
        .W     (WD_W)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear_s),
        .enable (wd_enable_s),
        .fire   (wd_fire_s)
    );

    // Which nodes may legitimately deliver a word this cycle.
    always_comb begin
        elig_s = '0;
        if (state_r == RUN) begin
            for (int i = 0; i < NUM_NODES; i++) begin
                if (cnt_r[i] < FULL) begin
                    if (mode_r == MODE_CONC) begin
                        elig_s[i] = 1'b1;
                    end else begin
                        elig_s[i] = (cur_r == NODE_W'(i));
                    end
                end else begin
                    elig_s[i] = 1'b0;
                end
            end
        end else begin
            elig_s = '0;
        end
    end

    assign good_s      = bus.node_valid & elig_s;
    assign stray_s     = bus.node_valid & ~elig_s;
    assign words_sum_s = {1'b0, words_r} + (TOT_W + 1)'(popcount(bus.node_valid));

    // Next-state, counter update, watchdog control and next enables.
    always_comb begin
        state_s     = state_r;
        mode_s      = mode_r;
        gap_s       = gap_r;
        gap_cnt_s   = gap_cnt_r;
        cur_s       = cur_r;
        cnt_s       = cnt_r;
        words_s     = words_r;
        err_s       = err_r;
        wd_clear_s  = 1'b1;
        wd_enable_s = 1'b0;
        all_full_s  = 1'b0;
        en_s        = '0;

        // Every valid during a schedule is totalled; only eligible ones
        // advance a node counter, the rest flag an error.
        if ((state_r == RUN) || (state_r == GAP)) begin
            words_s = words_sum_s[TOT_W] ? {TOT_W{1'b1}} : words_sum_s[TOT_W-1:0];
            if (stray_s != '0) begin
                err_s = 1'b1;
            end else begin
                err_s = err_r;
            end
            for (int i = 0; i < NUM_NODES; i++) begin
                if (good_s[i]) begin
                    cnt_s[i] = cnt_r[i] + CNT_W'(1);
                end else begin
                    cnt_s[i] = cnt_r[i];
                end
            end
        end else begin
            words_s = words_r;
        end

        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_s   = RUN;
                    mode_s    = bus.mode;
                    gap_s     = bus.gap_cycles;
                    gap_cnt_s = '0;
                    cur_s     = '0;
                    words_s   = '0;
                    err_s     = 1'b0;
                    for (int i = 0; i < NUM_NODES; i++) begin
                        cnt_s[i] = '0;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            RUN: begin
                wd_clear_s  = bus.hold | (good_s != '0);
                wd_enable_s = ~bus.hold & (good_s == '0);
                all_full_s  = 1'b1;
                for (int i = 0; i < NUM_NODES; i++) begin
                    all_full_s = all_full_s & (cnt_s[i] == FULL);
                end
                if (wd_fire_s) begin
                    // cur_node keeps pointing at the stalled node
                    state_s = DONE;
                    err_s   = 1'b1;
                end else if (mode_r == MODE_CONC) begin
                    state_s = all_full_s ? DONE : RUN;
                end else if (cnt_s[cur_r] == FULL) begin
                    if (cur_r == LAST_NODE) begin
                        state_s = DONE;
                    end else if (gap_r == '0) begin
                        cur_s      = cur_r + NODE_W'(1);
                        wd_clear_s = 1'b1;
                    end else begin
                        state_s   = GAP;
                        gap_cnt_s = '0;
                    end
                end else begin
                    state_s = RUN;
                end
            end
            GAP: begin
                if (gap_cnt_r == (gap_r - GAP_W'(1))) begin
                    state_s   = RUN;
                    cur_s     = cur_r + NODE_W'(1);
                    gap_cnt_s = '0;
                end else begin
                    gap_cnt_s = gap_cnt_r + GAP_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        if (state_s == RUN) begin
            if (mode_s == MODE_CONC) begin
                for (int i = 0; i < NUM_NODES; i++) begin
                    en_s[i] = ~bus.hold & (cnt_s[i] < FULL);
                end
            end else begin
                en_s[cur_s] = ~bus.hold;
            end
        end else begin
            en_s = '0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            mode_r    <= MODE_SEQ;
            gap_r     <= '0;
            gap_cnt_r <= '0;
            cur_r     <= '0;
            words_r   <= '0;
            err_r     <= 1'b0;
            en_r      <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            for (int i = 0; i < NUM_NODES; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            state_r   <= state_s;
            mode_r    <= mode_s;
            gap_r     <= gap_s;
            gap_cnt_r <= gap_cnt_s;
            cur_r     <= cur_s;
            words_r   <= words_s;
            err_r     <= err_s;
            en_r      <= en_s;
            busy_r    <= (state_s == RUN) || (state_s == GAP);
            done_r    <= (state_s == DONE);
            for (int i = 0; i < NUM_NODES; i++) begin
                cnt_r[i] <= cnt_s[i];
            end
        end
    end

    assign bus.node_en    = en_r;
    assign bus.cur_node   = (mode_r == MODE_CONC) ? '0 : cur_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.err        = err_r;
    assign bus.words_seen = words_r;

endmodule

// File: tb/tb_inject_scheduler.sv
// Scoreboard bench for inject_scheduler: behavioural one-shot buffers,
// directed scenarios pushing expected completion records, and a monitor
// that pops and compares each record when done rises.
module tb_inject_scheduler;
    import noc_inject_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inject_scheduler_if bus();

    inject_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [TOT_W-1:0]  words;
        logic              err;
        logic [NODE_W-1:0] cur;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Behavioural one-shot buffers
    logic [NUM_NODES-1:0] model_valid = '0;
    logic [NUM_NODES-1:0] armed       = '0;
    logic [NUM_NODES-1:0] stray       = '0;
    logic [NUM_NODES-1:0] mute        = '0;
    logic                 reload      = 1'b0;
    int                   remaining [NUM_NODES] = '{default: 0};
    int                   emitted   [NUM_NODES] = '{default: 0};

    assign bus.node_valid = model_valid | stray;

    // Buffer model: arm one cycle after enable, then one word per enabled cycle.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_valid <= '0;
            armed       <= '0;
        end else begin
            for (int i = 0; i < NUM_NODES; i++) begin
                if (reload) begin
                    remaining[i]   <= BUF_DEPTH;
                    emitted[i]     <= 0;
                    armed[i]       <= 1'b0;
                    model_valid[i] <= 1'b0;
                end else if (bus.node_en[i]) begin
                    armed[i] <= 1'b1;
                    if (armed[i] && (remaining[i] > 0) && !mute[i]) begin
                        model_valid[i] <= 1'b1;
                        remaining[i]   <= remaining[i] - 1;
                        emitted[i]     <= emitted[i] + 1;
                    end else begin
                        model_valid[i] <= 1'b0;
                    end
                end else begin
                    armed[i]       <= 1'b0;
                    model_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Sequential-mode enable observer: zero-enable cycles, gaps, one-hot shape.
    logic seq_watch = 1'b0;
    logic prev_zero = 1'b0;
    int   zero_cyc = 0, gap_events = 0, onehot_bad = 0;
    logic [NUM_NODES-1:0] one_v;
    always @(negedge clk) begin
        if (seq_watch && bus.busy) begin
            if (bus.node_en == '0) begin
                zero_cyc++;
                prev_zero = 1'b1;
            end else begin
                if (prev_zero) gap_events++;
                prev_zero = 1'b0;
                one_v = 1;
                one_v = one_v << bus.cur_node;
                if (bus.node_en != one_v) onehot_bad++;
            end
        end else begin
            prev_zero = 1'b0;
        end
    end

    // Monitor: compare completion status against the scoreboard head.
    logic done_prev = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.done && !done_prev) begin
                chk("sb_pending", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("sb_words", bus.words_seen, mon_e.words);
                    chk("sb_err", bus.err, mon_e.err);
                    chk("sb_cur_node", bus.cur_node, mon_e.cur);
                    chk("sb_node_en", bus.node_en, 0);
                    chk("sb_busy", bus.busy, 0);
                end
            end
            done_prev = bus.done;
        end
    end

    task automatic push_exp(input int w, input logic e, input int c);
        exp_t x;
        x.words = TOT_W'(w);
        x.err   = e;
        x.cur   = NODE_W'(c);
        exp_q.push_back(x);
    endtask

    task automatic do_reload(input logic [NUM_NODES-1:0] m);
        @(negedge clk);
        mute   = m;
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic pulse_start(input logic md, input logic [GAP_W-1:0] g);
        @(negedge clk);
        bus.mode       = md;
        bus.gap_cycles = g;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start      = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        chk(nm, seen, 1);
    endtask

    task automatic wait_node(input string nm, input int node, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (bus.cur_node == NODE_W'(node)) seen = 1'b1;
        end
        chk(nm, seen, 1);
    endtask

    function automatic int full_models();
        int n;
        n = 0;
        for (int i = 0; i < NUM_NODES; i++) begin
            if (emitted[i] == BUF_DEPTH) n++;
        end
        return n;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_node_en"}, bus.node_en, 0);
        chk({tag, "_cur_node"}, bus.cur_node, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_err"}, bus.err, 0);
        chk({tag, "_words"}, bus.words_seen, 0);
    endtask

    int   z0, g0, o0, conc_bad;
    logic hold_last;
    bit   seen_c;

    initial begin
        rst            = 1'b0;
        bus.start      = 1'b0;
        bus.mode       = MODE_SEQ;
        bus.gap_cycles = '0;
        bus.hold       = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst0");
        rst = 1'b1;

        // Sequential, no gap
        do_reload('0);
        push_exp(480, 1'b0, 15);
        z0 = zero_cyc; g0 = gap_events; o0 = onehot_bad;
        seq_watch = 1'b1;
        pulse_start(MODE_SEQ, 8'd0);
        wait_done("seq0_done", 3000);
        seq_watch = 1'b0;
        chk("seq0_zero_en_cycles", zero_cyc - z0, 0);
        chk("seq0_onehot", onehot_bad - o0, 0);
        chk("seq0_models_full", full_models(), 16);

        // Sequential, gap of 3 cycles
        do_reload('0);
        push_exp(480, 1'b0, 15);
        z0 = zero_cyc; g0 = gap_events; o0 = onehot_bad;
        seq_watch = 1'b1;
        pulse_start(MODE_SEQ, 8'd3);
        wait_done("seq3_done", 3000);
        seq_watch = 1'b0;
        chk("seq3_zero_en_cycles", zero_cyc - z0, 45);
        chk("seq3_gap_events", gap_events - g0, 15);
        chk("seq3_onehot", onehot_bad - o0, 0);

        // Concurrent with hold every 4th cycle
        do_reload('0);
        push_exp(480, 1'b0, 0);
        pulse_start(MODE_CONC, 8'd0);
        conc_bad  = 0;
        hold_last = 1'b0;
        seen_c    = 1'b0;
        for (int k = 0; k < 3000 && !seen_c; k++) begin
            if (k < 20) begin
                if (bus.node_en != (hold_last ? 16'h0000 : 16'hFFFF)) conc_bad++;
            end
            if (bus.done) seen_c = 1'b1;
            bus.hold  = ((k % 4) == 3) && !seen_c;
            hold_last = bus.hold;
            @(negedge clk);
        end
        bus.hold = 1'b0;
        chk("conc_done", seen_c, 1);
        chk("conc_en_pattern", conc_bad, 0);
        chk("conc_models_full", full_models(), 16);

        // Node 5 never streams: watchdog
        do_reload(16'h0020);
        push_exp(150, 1'b1, 5);
        pulse_start(MODE_SEQ, 8'd0);
        wait_done("wd_done", 3000);

        // Stray valid on node 9 while node 2 is served
        do_reload('0);
        push_exp(481, 1'b1, 15);
        pulse_start(MODE_SEQ, 8'd0);
        wait_node("stray_reach2", 2, 500);
        stray = 16'h0200;
        @(negedge clk);
        stray = '0;
        wait_done("stray_done", 3000);

        // Reset in the middle of a run, then restart
        do_reload('0);
        pulse_start(MODE_SEQ, 8'd0);
        wait_node("mid_reach7", 7, 1000);
        rst = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        @(negedge clk);
        rst = 1'b1;
        do_reload('0);
        push_exp(480, 1'b0, 15);
        pulse_start(MODE_SEQ, 8'd0);
        chk("restart_cur_node", bus.cur_node, 0);
        chk("restart_node_en", bus.node_en, 16'h0001);
        wait_done("restart_done", 3000);

        repeat (3) @(negedge clk);
        chk("sb_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inject_scheduler.md
Name: inject_scheduler

Overview:
- Sequences the 16 per-node one-shot injection buffers that feed the NoC.
- Drives each buffer's enable and counts its out_valid pulses to know when the buffer has finished its burst.
- Supports two modes: one node at a time (round-robin, with a programmable inter-node gap) or all nodes concurrently.
- Global hold from the network side pauses injection; a watchdog flags a buffer that never streams.

Parameters:
- NUM_NODES, 16, number of injection buffers (power of 2).
- NODE_W, 4, width of node index (log2 NUM_NODES).
- BUF_DEPTH, 30, words each buffer emits per burst (valid pulses expected per node).
- CNT_W, 5, width of per-node word counter (holds 0..BUF_DEPTH).
- TOT_W, 10, width of total word counter (holds NUM_NODES*BUF_DEPTH = 480).
- TIMEOUT, 64, cycles without progress before the watchdog fires.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a schedule when in IDLE or DONE.
- mode  in  1  0 = sequential, 1 = concurrent; sampled on accepted start.
- gap_cycles  in  8  idle cycles between nodes in sequential mode; sampled on accepted start.
- hold  in  1  network backpressure; while 1, all node_en are forced low.
- node_valid  in  NUM_NODES  out_valid from each buffer.
- node_en  out  NUM_NODES  enable to each buffer.
- cur_node  out  NODE_W  node being served (sequential); 0 in concurrent mode.
- busy  out  1  high in RUN or GAP.
- done  out  1  level; high in DONE until the next accepted start.
- err  out  1  sticky; cleared on accepted start.
- words_seen  out  TOT_W  total valid pulses counted since the last accepted start.

Behaviour:
- Reset values: node_en=0, cur_node=0, busy=0, done=0, err=0, words_seen=0, state=IDLE, all counters 0.
- Reset mid-run aborts immediately to these values.
- Accepted start (in IDLE or DONE):
  - Latches mode and gap_cycles.
  - Clears err, words_seen and per-node counters; cur_node=0.
  - Next state is RUN. start while busy is ignored.
- RUN, sequential mode:
  - node_en[cur_node] = ~hold; all other enables are 0. node_en is registered, so it takes effect the cycle after entering RUN.
  - Each node_valid[cur_node] pulse increments that node's counter and words_seen.
  - The cycle the counter reaches BUF_DEPTH, node_en drops the next cycle.
  - Last node (cur_node = NUM_NODES-1): go to DONE.
  - Else if gap_cycles=0: cur_node++ and stay in RUN.
  - Else go to GAP.
- GAP: all node_en=0 for exactly gap_cycles cycles, then cur_node++ and return to RUN.
- RUN, concurrent mode:
  - node_en[i] = ~hold for every node whose counter is < BUF_DEPTH; 0 otherwise.
  - Multiple valids in one cycle all count; words_seen adds the popcount.
  - When all counters equal BUF_DEPTH, go to DONE.
- DONE: node_en=0, done=1, busy=0.
- Buffer handshake:
  - A buffer emits its first valid two cycles after enable rises (one cycle to arm, one to output).
  - Dropping enable pauses it without loss.
  - So hold may toggle arbitrarily; counts stay exact.
- Unexpected valid: a valid on a node that is not enabled-eligible (sequential non-current node, or counter already full):
  - Sets err.
  - Is counted in words_seen but not in any node counter.
  - Does not alter state.
- Watchdog:
  - Counter increments in RUN while hold=0 and no eligible valid arrives.
  - Resets on any eligible valid, on any hold cycle, and on node change.
  - On reaching TIMEOUT: set err and go to DONE, with node_en=0. cur_node retains the failing node.
- Restart: buffers are one-shot. A restart without resetting the buffers ends in watchdog err; this is intended behaviour.
- Counters saturate; they never wrap.

Decomposition:
- Shared package noc_inject_pkg:
  - State enum IDLE/RUN/GAP/DONE.
  - MODE_SEQ/MODE_CONC constants.
  - Default NUM_NODES, BUF_DEPTH.
- One sub-module: inject_watchdog (timeout counter with clear/enable inputs, fire output).
- The per-node counter array stays inline.

Test Plan:
- Sequential, gap=0, hold=0, 16 behavioural buffer models → node_en one-hot walks 0..15, each held until 30 valids; done=1; words_seen=480; err=0.
- Sequential, gap=3 → exactly 3 cycles with node_en=0 between consecutive nodes; cur_node increments on GAP exit; words_seen=480.
- Concurrent, hold toggled 1 every 4th cycle → node_en all-ones except during hold; each node counter reaches 30; done=1; words_seen=480.
- Node 5 model never asserts valid, TIMEOUT=64 → err=1, done=1, cur_node=5, words_seen=150, node_en=0.
- Stray valid on node 9 while serving node 2 (sequential) → err=1, schedule completes, words_seen=481.
- Reset asserted mid-RUN at cur_node=7, then released and start pulsed → all outputs return to reset values; new run begins at node 0.
